// File: rtl/add_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_sum_pkg
// Brief    : Shared adder constants and the result record {sum, cout, ovf}.
//            ADD_SUM_OVF_EN selects whether the ovf bit is stored per entry.
// Revision : 1.0 - initial release
// ============================================================================
package add_sum_pkg;

   localparam int ADD_WIDTH = 32;
   localparam int FIELD_W   = 2;

   // Result record as presented on the output ports.
   typedef struct packed {
      logic [ADD_WIDTH-1:0] sum;
      logic                 cout;
      logic                 ovf;
   } add_result_t;

   // Stored width per FIFO entry: the ovf bit is kept only when enabled.
`ifdef ADD_SUM_OVF_EN
   localparam int RES_STORE_W = ADD_WIDTH + 2;
`else
   localparam int RES_STORE_W = ADD_WIDTH + 1;
`endif

endpackage : add_sum_pkg
`default_nettype wire

// File: rtl/add_sum_fifo.sv
`default_nettype none
// ============================================================================
// Module   : add_sum_fifo
// Brief    : Valid/ready FIFO with wrapping read/write pointers and an
//            occupancy count. Head data reads as zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module add_sum_fifo #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 33
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_valid_i,
   output logic              push_ready_o,
   input  logic [DATA_W-1:0] push_data_i,
   output logic              pop_valid_o,
   input  logic              pop_ready_i,
   output logic [DATA_W-1:0] pop_data_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full       = (count_q == CNT_W'(DEPTH));
   assign w_empty      = (count_q == '0);
   assign w_pop        = !w_empty && pop_ready_i;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push_ready_o = !w_full || w_pop;
   assign w_push       = push_valid_i && push_ready_o;
   assign pop_valid_o  = !w_empty;
   // Forcing zero while empty keeps outputs stable and clean after reset.
   assign pop_data_o   = w_empty ? '0 : mem_q[rd_ptr_q];

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only observable through a valid head.
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule : add_sum_fifo
`default_nettype wire

// File: rtl/add_sum_stage.sv
`default_nettype none
// ============================================================================
// Module   : add_sum_stage
// Brief    : Final sum stage of a prefix adder: sum_i = hsum_i ^ g_(i-1),
//            cout = g_31, buffered in a valid/ready output FIFO.
//            ADD_SUM_OVF_EN enables the signed overflow flag (g_30 ^ g_31);
//            otherwise ovf is tied low and not stored.
// Revision : 1.0 - initial release
// ============================================================================
module add_sum_stage
   import add_sum_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [FIELD_W*ADD_WIDTH-1:0] temp_4,
   input  logic [ADD_WIDTH-1:0]     hsum,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADD_WIDTH-1:0]     sum,
   output logic                     cout,
   output logic                     ovf
);

   logic [ADD_WIDTH-1:0]   w_g;
   logic [ADD_WIDTH-1:0]   w_p;
   logic                   w_unused_p;
   logic [ADD_WIDTH-1:0]   w_sum;
   logic                   w_cout;
   logic [RES_STORE_W-1:0] w_push_data;
   logic [RES_STORE_W-1:0] w_pop_data;
   add_result_t            w_head;

   // Split the prefix fields into generate and propagate vectors.
   always_comb begin
      w_g = '0;
      w_p = '0;
      for (int i = 0; i < ADD_WIDTH; i++) begin
         w_g[i] = temp_4[FIELD_W*i+1];
         w_p[i] = temp_4[FIELD_W*i];
      end
   end

   // Propagate bits play no part in the final sum.
   assign w_unused_p = ^w_p;

   // Carry into bit i is the resolved generate of bit i-1; carry-in is 0.
   assign w_sum  = hsum ^ {w_g[ADD_WIDTH-2:0], 1'b0};
   assign w_cout = w_g[ADD_WIDTH-1];

`ifdef ADD_SUM_OVF_EN
   assign w_push_data = {w_sum, w_cout, w_g[ADD_WIDTH-2] ^ w_g[ADD_WIDTH-1]};
   assign w_head      = w_pop_data;
`else
   assign w_push_data = {w_sum, w_cout};
   assign w_head      = {w_pop_data, 1'b0};
`endif

   add_sum_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (RES_STORE_W)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_valid_i (in_valid),
      .push_ready_o (in_ready),
      .push_data_i  (w_push_data),
      .pop_valid_o  (out_valid),
      .pop_ready_i  (out_ready),
      .pop_data_o   (w_pop_data)
   );

   assign sum  = w_head.sum;
   assign cout = w_head.cout;
   assign ovf  = w_head.ovf;

endmodule : add_sum_stage
`default_nettype wire
